// File: rtl/dram_bank_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dram_bank_sched : open-page DRAM bank scheduler with open-row table and    |
// |                   refresh interleave. Define DRAM_SCHED_CLOSED_PAGE_EN to   |
// |                   precharge the bank after every READ/WRITE.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dram_bank_sched #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_REF        = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_val,
    output logic                            req_rdy,
    input  logic                            req_rw,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] req_bank,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  req_row,
    input  logic [$clog2(NUM_OF_COLS)-1:0]  req_col,
    input  logic                            refresh_flag,
    output logic                            cmd_req,
    input  logic                            cmd_ack,
    output logic [1:0]                      cmd,
    output logic                            cmd_all,
    output logic [$clog2(NUM_OF_BANKS)-1:0] cmd_bank,
    output logic [$clog2(NUM_OF_ROWS)-1:0]  cmd_row,
    output logic [$clog2(NUM_OF_COLS)-1:0]  cmd_col,
    output logic                            ref_busy,
    output logic                            ref_done,
    output logic                            row_hit
);

    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int ROW_W  = $clog2(NUM_OF_ROWS);
    localparam int CNT_W  = (T_REF > 1) ? $clog2(T_REF) : 1;

    localparam logic [1:0]       c_CMD_ACT  = 2'b00;
    localparam logic [1:0]       c_CMD_RD   = 2'b01;
    localparam logic [1:0]       c_CMD_WR   = 2'b10;
    localparam logic [1:0]       c_CMD_PRE  = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(T_REF - 1);
    localparam logic [CNT_W-1:0] c_CNT_PRE  = CNT_W'((T_REF >= 2) ? (T_REF - 2) : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ACT, S_RW, S_CLOSE, S_REF_PRE, S_REF_WAIT
    } state_t;

    state_t                  r_state;
    logic [NUM_OF_BANKS-1:0] r_valid;
    logic [ROW_W-1:0]        r_row [NUM_OF_BANKS];
    logic                    r_rw;
    logic [CNT_W-1:0]        r_cnt;
    logic                    w_ack;
    logic                    w_hit;

    assign req_rdy = (r_state == S_IDLE) && !refresh_flag;
    assign w_ack   = cmd_req && cmd_ack;
    assign w_hit   = r_valid[req_bank] && (r_row[req_bank] == req_row);

    // cmd_bank/cmd_row/cmd_col double as the latched request address for the
    // whole PRE/ACT/RW sequence; they only change when a new request or a
    // refresh is started from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_valid  <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) r_row[i] <= '0;
            r_rw     <= 1'b0;
            r_cnt    <= '0;
            cmd_req  <= 1'b0;
            cmd      <= c_CMD_ACT;
            cmd_all  <= 1'b0;
            cmd_bank <= '0;
            cmd_row  <= '0;
            cmd_col  <= '0;
            ref_busy <= 1'b0;
            ref_done <= 1'b0;
            row_hit  <= 1'b0;
        end else begin
            ref_done <= 1'b0;
            row_hit  <= 1'b0;

            if (w_ack) begin
                if (cmd == c_CMD_ACT) begin
                    r_valid[cmd_bank] <= 1'b1;
                    r_row[cmd_bank]   <= cmd_row;
                end else if (cmd == c_CMD_PRE) begin
                    if (cmd_all) r_valid <= '0;
                    else         r_valid[cmd_bank] <= 1'b0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (refresh_flag) begin
                        ref_busy <= 1'b1;
                        if (|r_valid) begin
                            cmd_req  <= 1'b1;
                            cmd      <= c_CMD_PRE;
                            cmd_all  <= 1'b1;
                            cmd_bank <= '0;
                            cmd_row  <= '0;
                            cmd_col  <= '0;
                            r_state  <= S_REF_PRE;
                        end else begin
                            r_cnt    <= '0;
                            ref_done <= (T_REF == 1);
                            r_state  <= S_REF_WAIT;
                        end
                    end else if (req_val) begin
                        r_rw     <= req_rw;
                        row_hit  <= w_hit;
                        cmd_req  <= 1'b1;
                        cmd_all  <= 1'b0;
                        cmd_bank <= req_bank;
                        cmd_row  <= req_row;
                        cmd_col  <= req_col;
                        if (w_hit) begin
                            cmd     <= req_rw ? c_CMD_WR : c_CMD_RD;
                            r_state <= S_RW;
                        end else if (r_valid[req_bank]) begin
                            cmd     <= c_CMD_PRE;
                            r_state <= S_PRE;
                        end else begin
                            cmd     <= c_CMD_ACT;
                            r_state <= S_ACT;
                        end
                    end
                end
                // Each command state issues one cycle after entry (cmd_req low)
                // and advances on the ack, giving the idle cycle between commands.
                S_PRE: begin
                    if (!cmd_req) begin
                        cmd_req <= 1'b1;
                        cmd     <= c_CMD_PRE;
                    end else if (cmd_ack) begin
                        cmd_req <= 1'b0;
                        r_state <= S_ACT;
                    end
                end
                S_ACT: begin
                    if (!cmd_req) begin
                        cmd_req <= 1'b1;
                        cmd     <= c_CMD_ACT;
                    end else if (cmd_ack) begin
                        cmd_req <= 1'b0;
                        r_state <= S_RW;
                    end
                end
                S_RW: begin
                    if (!cmd_req) begin
                        cmd_req <= 1'b1;
                        cmd     <= r_rw ? c_CMD_WR : c_CMD_RD;
                    end else if (cmd_ack) begin
                        cmd_req <= 1'b0;
`ifdef DRAM_SCHED_CLOSED_PAGE_EN
                        r_state <= S_CLOSE;
`else
                        r_state <= S_IDLE;
`endif
                    end
                end
                S_CLOSE: begin
                    if (!cmd_req) begin
                        cmd_req <= 1'b1;
                        cmd     <= c_CMD_PRE;
                    end else if (cmd_ack) begin
                        cmd_req <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_REF_PRE: begin
                    if (cmd_ack) begin
                        cmd_req  <= 1'b0;
                        cmd_all  <= 1'b0;
                        r_cnt    <= '0;
                        ref_done <= (T_REF == 1);
                        r_state  <= S_REF_WAIT;
                    end
                end
                S_REF_WAIT: begin
                    if (r_cnt == c_CNT_LAST) begin
                        ref_busy <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                        ref_done <= (r_cnt == c_CNT_PRE);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dram_bank_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dram_bank_sched : directed + random bench for dram_bank_sched against a  |
// |                      command-sequence reference model.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dram_bank_sched;

    localparam int NB   = 8;
    localparam int TREF = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_val, req_rdy, req_rw;
    logic [2:0] req_bank;
    logic [6:0] req_row;
    logic [2:0] req_col;
    logic       refresh_flag;
    logic       cmd_req, cmd_ack;
    logic [1:0] cmd;
    logic       cmd_all;
    logic [2:0] cmd_bank;
    logic [6:0] cmd_row;
    logic [2:0] cmd_col;
    logic       ref_busy, ref_done, row_hit;

    always #5 clk = ~clk;

    dram_bank_sched #(.NUM_OF_BANKS(NB), .NUM_OF_ROWS(128), .NUM_OF_COLS(8), .T_REF(TREF)) u_dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy), .req_rw(req_rw),
        .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .refresh_flag(refresh_flag),
        .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd(cmd), .cmd_all(cmd_all),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .ref_busy(ref_busy), .ref_done(ref_done), .row_hit(row_hit)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: open-row table plus the expected command list per request.
    typedef struct {
        int c;
        int b;
        int r;
        int cl;
        bit all;
    } cmd_t;

    bit   m_valid [NB];
    int   m_row   [NB];
    cmd_t exp_q[$];

    function automatic cmd_t mk(input int c, input int b, input int r, input int cl, input bit all);
        cmd_t t;
        t.c = c; t.b = b; t.r = r; t.cl = cl; t.all = all;
        return t;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 1'b0;
            m_row[i]   = 0;
        end
    endtask

    task automatic plan(input int rw, input int bank, input int row, input int col, output bit hit);
        exp_q.delete();
        hit = m_valid[bank] && (m_row[bank] == row);
        if (!hit) begin
            if (m_valid[bank]) exp_q.push_back(mk(3, bank, 0, 0, 1'b0));
            exp_q.push_back(mk(0, bank, row, 0, 1'b0));
        end
        exp_q.push_back(mk(rw ? 2 : 1, bank, 0, col, 1'b0));
        m_valid[bank] = 1'b1;
        m_row[bank]   = row;
`ifdef DRAM_SCHED_CLOSED_PAGE_EN
        exp_q.push_back(mk(3, bank, 0, 0, 1'b0));
        m_valid[bank] = 1'b0;
`endif
    endtask

    task automatic cmp_cmd(input cmd_t e);
        check("cmd", {30'd0, cmd}, e.c);
        check("cmd_all", {31'd0, cmd_all}, {31'd0, e.all});
        if (!e.all) check("cmd_bank", {29'd0, cmd_bank}, e.b);
        if (e.c == 0) check("cmd_row", {25'd0, cmd_row}, e.r);
        if (e.c == 1 || e.c == 2) check("cmd_col", {29'd0, cmd_col}, e.cl);
    endtask

    // Entered at the negedge of the cycle where the first command must be up.
    task automatic serve_cmds(input int hold_act, input bit abort_pre, output bit aborted);
        int d;
        aborted = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin
                @(negedge clk);
                check("gap_high", {31'd0, cmd_req}, 1);
            end else begin
                check("cmd_lat", {31'd0, cmd_req}, 1);
            end
            cmp_cmd(exp_q[k]);
            if (abort_pre && exp_q[k].c == 3) begin
                aborted = 1'b1;
                return;
            end
            d = (exp_q[k].c == 0 && hold_act >= 0) ? hold_act : int'($urandom_range(0, 3));
            for (int h = 0; h < d; h++) begin
                @(negedge clk);
                check("hold_req", {31'd0, cmd_req}, 1);
                cmp_cmd(exp_q[k]);
            end
            cmd_ack = 1'b1;
            @(negedge clk);
            cmd_ack = 1'b0;
            check("gap_low", {31'd0, cmd_req}, 0);
        end
    endtask

    task automatic do_request(input int rw, input int bank, input int row, input int col,
                              input int hold_act, input bit abort_pre);
        bit hit;
        bit ab;
        int n;
        plan(rw, bank, row, col, hit);
        req_val  = 1'b1;
        req_rw   = rw[0];
        req_bank = bank[2:0];
        req_row  = row[6:0];
        req_col  = col[2:0];
        #1;
        n = 0;
        while (!req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) begin
            check("rdy_timeout", {31'd0, req_rdy}, 1);
            req_val = 1'b0;
            return;
        end
        @(negedge clk);
        req_val = 1'b0;
        check("row_hit", {31'd0, row_hit}, {31'd0, hit});
        serve_cmds(hold_act, abort_pre, ab);
        if (!ab) begin
            check("rdy_back", {31'd0, req_rdy}, 1);
            check("row_hit_once", {31'd0, row_hit}, 0);
        end
    endtask

    task automatic do_refresh(input bit with_req, input int rw, input int bank, input int row, input int col);
        bit anyv;
        bit ab;
        refresh_flag = 1'b1;
        if (with_req) begin
            req_val  = 1'b1;
            req_rw   = rw[0];
            req_bank = bank[2:0];
            req_row  = row[6:0];
            req_col  = col[2:0];
        end
        #1;
        check("rdy_ref", {31'd0, req_rdy}, 0);
        @(negedge clk);
        check("ref_busy_rise", {31'd0, ref_busy}, 1);
        anyv = 1'b0;
        for (int i = 0; i < NB; i++) anyv |= m_valid[i];
        exp_q.delete();
        if (anyv) exp_q.push_back(mk(3, 0, 0, 0, 1'b1));
        clear_model();
        if (anyv) serve_cmds(-1, 1'b0, ab);
        for (int i = 0; i < TREF; i++) begin
            check("ref_busy_wait", {31'd0, ref_busy}, 1);
            check("ref_done", {31'd0, ref_done}, (i == TREF - 1) ? 1 : 0);
            check("rdy_in_ref", {31'd0, req_rdy}, 0);
            if (i == TREF - 1) refresh_flag = 1'b0;
            @(negedge clk);
        end
        check("ref_busy_fall", {31'd0, ref_busy}, 0);
        check("ref_done_end", {31'd0, ref_done}, 0);
    endtask

    initial begin
        bit wr;
        rst = 1'b1; req_val = 1'b0; req_rw = 1'b0; req_bank = '0; req_row = '0; req_col = '0;
        refresh_flag = 1'b0; cmd_ack = 1'b0;
        clear_model();
        #1;
        check("rst_cmd_req", {31'd0, cmd_req}, 0);
        check("rst_cmd", {30'd0, cmd}, 0);
        check("rst_cmd_all", {31'd0, cmd_all}, 0);
        check("rst_addr", {19'd0, cmd_bank, cmd_row, cmd_col}, 0);
        check("rst_flags", {29'd0, ref_busy, ref_done, row_hit}, 0);
        check("rst_rdy", {31'd0, req_rdy}, 1);
        refresh_flag = 1'b1;
        #1;
        check("rst_rdy_ref", {31'd0, req_rdy}, 0);
        refresh_flag = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_request(0, 2, 5, 3, -1, 1'b0);   // closed bank
        do_request(1, 2, 5, 6, -1, 1'b0);   // hit
        do_request(0, 2, 9, 0, -1, 1'b0);   // conflict
        do_refresh(1'b1, 0, 3, 7, 1);
        do_request(0, 3, 7, 1, -1, 1'b0);
        do_request(1, 6, 20, 4, 10, 1'b0);  // slow ACTIVATE ack

        cmd_ack = 1'b1;                     // stray ack in IDLE
        @(negedge clk);
        cmd_ack = 1'b0;
        check("stray_cmd_req", {31'd0, cmd_req}, 0);
        check("stray_rdy", {31'd0, req_rdy}, 1);
        do_request(0, 6, 20, 5, -1, 1'b0);

        do_request(0, 4, 10, 1, -1, 1'b0);
        do_request(0, 4, 11, 2, -1, 1'b1);  // stops while PRECHARGE is pending
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_req", {31'd0, cmd_req}, 0);
        check("mid_rst_cmd", {30'd0, cmd}, 0);
        check("mid_rst_flags", {29'd0, ref_busy, ref_done, row_hit}, 0);
        check("mid_rst_rdy", {31'd0, req_rdy}, 1);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        do_request(0, 4, 11, 2, -1, 1'b0);

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                wr = 1'(($urandom_range(0, 1)));
                if (wr) begin
                    do_refresh(1'b1, 1, 1, 2, 3);
                    do_request(1, 1, 2, 3, -1, 1'b0);
                end else begin
                    do_refresh(1'b0, 0, 0, 0, 0);
                end
            end else begin
                do_request(int'($urandom_range(0, 1)), int'($urandom_range(0, NB - 1)),
                           int'($urandom_range(0, 2)), int'($urandom_range(0, 7)), -1, 1'b0);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_bank_sched.md
# dram_bank_sched

Open-page bank scheduler between the controller's address-translation stage and the DRAM command interface. It accepts one translated request at a time (bank/row/col, read or write) and tracks the open row of every bank. It emits the ACTIVATE / READ / WRITE / PRECHARGE sequence over the existing cmd_req/cmd_ack handshake, and interleaves refresh (precharge-all plus refresh window) when the refresh counter flags.

## Interface
- NUM_OF_BANKS, 8, bank count; bank index width is $clog2(NUM_OF_BANKS)
- NUM_OF_ROWS, 128, rows per bank; row index width is $clog2(NUM_OF_ROWS)
- NUM_OF_COLS, 8, columns per row; column index width is $clog2(NUM_OF_COLS)
- T_REF, 4, cycles the refresh window is held after precharge-all (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_val  in  1  request valid
- req_rdy  out  1  scheduler ready; a request is accepted on a clk edge where req_val && req_rdy
- req_rw  in  1  1=write, 0=read
- req_bank  in  3  target bank
- req_row  in  7  target row
- req_col  in  3  target column
- refresh_flag  in  1  level refresh request from refresh counter
- cmd_req  out  1  command valid
- cmd_ack  in  1  command accepted, single-cycle pulse
- cmd  out  2  00 ACTIVATE, 01 READ, 10 WRITE, 11 PRECHARGE
- cmd_all  out  1  qualifies PRECHARGE as precharge-all
- cmd_bank / cmd_row / cmd_col  out  3/7/3  command address
- ref_busy  out  1  high from refresh start to refresh end
- ref_done  out  1  one-cycle pulse at end of refresh window (clears refresh counter)
- row_hit  out  1  one-cycle pulse, cycle after accept, when the request hits an open row

## Operation
- Open-row table: per bank a valid bit and a row register.
  - Reset: all valid bits = 0.
  - ACTIVATE ack: valid=1, row=cmd_row.
  - PRECHARGE ack: valid=0.
  - Precharge-all ack: all valid=0.
- States:
  - IDLE: req_rdy = !refresh_flag. If refresh_flag=1, go to REF_PRE; this has priority over a simultaneous req_val. Else on accept, latch the request, then:
    - hit (valid && row match) → RW
    - bank closed → ACT
    - row conflict → PRE
  - PRE: PRECHARGE to the latched bank → ACT.
  - ACT: ACTIVATE with the latched bank/row → RW.
  - RW: READ or WRITE per req_rw, with bank/col → IDLE.
  - REF_PRE: if any bank is valid, issue PRECHARGE with cmd_all=1 → REF_WAIT. Else go directly to REF_WAIT.
  - REF_WAIT: count T_REF cycles, then pulse ref_done → IDLE.
- Only one command is outstanding at a time. cmd_req stays high, and cmd/cmd_all/cmd_bank/cmd_row/cmd_col stay stable, until cmd_ack is sampled.
- refresh_flag is sampled only in IDLE; a request in flight completes first.
- cmd_ack while cmd_req=0 is ignored.
- rst mid-operation:
  - FSM returns to IDLE.
  - The outstanding command is abandoned.
  - The table is invalidated.
  - All outputs return to reset values.

## Timing
- Reset values:
  - cmd_req=0, cmd=00, cmd_all=0, cmd_bank=0, cmd_row=0, cmd_col=0.
  - ref_busy=0, ref_done=0, row_hit=0.
  - req_rdy=!refresh_flag.
- All outputs are registered except req_rdy, which is combinational from state and refresh_flag.
- Command latency: request accepted at edge N → first cmd_req high in cycle N+1.
- Command spacing: cmd_ack sampled at edge M → cmd_req low in cycle M+1. The next command's cmd_req goes high in cycle M+2.
- Per-request command count: hit = 1 (RW), closed = 2 (ACT, RW), conflict = 3 (PRE, ACT, RW).
- req_rdy returns high in the cycle after the RW ack edge.
- Refresh:
  - ref_busy rises the cycle after IDLE sees refresh_flag.
  - REF_WAIT lasts exactly T_REF cycles.
  - ref_done pulses in the last REF_WAIT cycle.
  - ref_busy falls on the following edge.

## Configuration
- DRAM_SCHED_CLOSED_PAGE_EN:
  - Defined: closed-page policy. After every RW ack, a PRECHARGE to the same bank is issued before returning to IDLE. Every request is a closed-bank case (2+1 commands), row_hit never pulses, and REF_PRE never needs precharge-all.
  - Undefined: open-page policy as described above.

## Test plan
- Reset, then read bank 2 row 5 col 3 → ACTIVATE(2,5) then READ(2,col 3); table[2] valid row 5; row_hit=0.
- Same bank 2 row 5, write col 6 → single WRITE(2,col 6); row_hit pulses once.
- Bank 2 row 9 → PRECHARGE(2), ACTIVATE(2,9), READ; each cmd_req rises exactly 2 cycles after the previous ack.
- refresh_flag and req_val rise together in IDLE → req_rdy=0; PRECHARGE with cmd_all=1; ref_busy high; ref_done after T_REF=4 cycles; then the request is accepted and needs ACTIVATE.
- Hold cmd_ack low for 10 cycles during ACTIVATE → cmd_req and the address stay stable; a stray cmd_ack in IDLE has no effect.
- Assert rst while waiting on a PRE ack → cmd_req=0 immediately; after release, a request to that bank issues ACTIVATE (table cleared).
